// File: rtl/seq_counter_pkg.sv
// Shared mode encodings and Gray-code helpers for the sequence counter.
// The helpers work on MaxWidth bits; narrower callers zero-extend and truncate.
package seq_counter_pkg;

  localparam int unsigned MaxWidth = 8;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_TBL  = 2'b11;

  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] gray);
    logic [MaxWidth-1:0] bin;
    bin[MaxWidth-1] = gray[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/seq_counter_n_if.sv
// Control/status bundle of the sequence counter: step/load controls, table
// write port and the registered counter outputs.
interface seq_counter_n_if #(
  parameter int unsigned WIDTH = 3
);
  logic             en;
  logic             load_n;
  logic [WIDTH-1:0] d;
  logic [1:0]       mode;
  logic             tbl_we;
  logic [WIDTH-1:0] tbl_addr;
  logic [WIDTH-1:0] tbl_wdata;
  logic [WIDTH-1:0] q;
  logic             tc;

  modport master (
    output en, load_n, d, mode, tbl_we, tbl_addr, tbl_wdata,
    input  q, tc
  );

  modport slave (
    input  en, load_n, d, mode, tbl_we, tbl_addr, tbl_wdata,
    output q, tc
  );
endinterface

// File: rtl/seq_next_table.sv
// Programmable next-state table: 2**WIDTH entries, reset to i+1 (mod 2**WIDTH),
// one synchronous write port and one combinational read port.
module seq_next_table #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  localparam int unsigned Depth = 2 ** WIDTH;

  logic [WIDTH-1:0] tbl_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        tbl_q[i] <= WIDTH'(i + 1);
      end
    end else if (we) begin
      tbl_q[waddr] <= wdata;
    end
  end

  // Read sees the pre-write contents, so a same-cycle step uses the old entry.
  assign rdata = tbl_q[raddr];

endmodule

// File: rtl/seq_counter_n.sv
// Sequence counter: up/down (wrapping at MODULUS), Gray, or table-driven stepping,
// with active-low parallel load and a registered terminal-count pulse.
module seq_counter_n
  import seq_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_counter_n_if.slave bus
);
  localparam logic [WIDTH-1:0] ModMax = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ModW   = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] step_q;
  logic             step_tc;
  logic [WIDTH-1:0] tbl_next;
  logic [WIDTH-1:0] gray_bin;

  seq_next_table #(
    .WIDTH(WIDTH)
  ) u_table (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (bus.tbl_we),
    .waddr(bus.tbl_addr),
    .wdata(bus.tbl_wdata),
    .raddr(q_q),
    .rdata(tbl_next)
  );

  always_comb begin
    gray_bin = WIDTH'(gray2bin(MaxWidth'(q_q)) + 1'b1);
    step_q   = '0;
    step_tc  = 1'b0;
    unique case (bus.mode)
      MODE_UP: begin
        // Out-of-range values (loaded above MODULUS-1) also wrap to 0.
        step_q  = (q_q == ModMax || {1'b0, q_q} >= ModW) ? '0 : q_q + 1'b1;
        step_tc = (step_q == '0);
      end
      MODE_DOWN: begin
        step_q  = (q_q == '0) ? ModMax : q_q - 1'b1;
        step_tc = (q_q == '0);
      end
      MODE_GRAY: begin
        step_q  = WIDTH'(bin2gray(MaxWidth'(gray_bin)));
        step_tc = (step_q == '0);
      end
      default: begin
        step_q  = tbl_next;
        step_tc = (step_q == '0);
      end
    endcase
  end

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (!bus.load_n) begin
      q_d = bus.d;
    end else if (bus.en) begin
      q_d  = step_q;
      tc_d = step_tc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign bus.q  = q_q;
  assign bus.tc = tc_q;

endmodule

// File: tb/tb_seq_counter_n.sv
// Scoreboard bench: two counters (MODULUS 8 and 6) share stimulus; a behavioural model
// queues expected q/tc per step and a monitor compares once per clock.
module tb_seq_counter_n;

  typedef struct packed {
    logic [2:0] q;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, load_n, tbl_we;
  logic [2:0] d, tbl_addr, tbl_wdata;
  logic [1:0] mode;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned mod_v [2] = '{8, 6};
  int          m_q   [2];
  logic        m_tc  [2];
  int          m_tbl [2][8];
  exp_t        exp0[$], exp1[$];

  always #5 clk = ~clk;

  seq_counter_n_if #(.WIDTH(3)) bus8 ();
  seq_counter_n_if #(.WIDTH(3)) bus6 ();

  assign bus8.en = en;         assign bus6.en = en;
  assign bus8.load_n = load_n; assign bus6.load_n = load_n;
  assign bus8.d = d;           assign bus6.d = d;
  assign bus8.mode = mode;     assign bus6.mode = mode;
  assign bus8.tbl_we = tbl_we; assign bus6.tbl_we = tbl_we;
  assign bus8.tbl_addr = tbl_addr;   assign bus6.tbl_addr = tbl_addr;
  assign bus8.tbl_wdata = tbl_wdata; assign bus6.tbl_wdata = tbl_wdata;

  seq_counter_n #(.WIDTH(3), .MODULUS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  seq_counter_n #(.WIDTH(3), .MODULUS(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

  function automatic int g2b(input int g);
    int b = 0;
    for (int x = g; x != 0; x = x >> 1) b = b ^ x;
    return b;
  endfunction

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [2:0] gq, input logic gtc, input exp_t e);
    n_checks++;
    if (gq !== e.q || gtc !== e.tc) begin
      n_errors++;
      $display("FAIL %s @%0t: got q=%0d tc=%0b, expected q=%0d tc=%0b",
               name, $time, gq, gtc, e.q, e.tc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k]  = 0;
      m_tc[k] = 1'b0;
      for (int i = 0; i < 8; i++) m_tbl[k][i] = (i + 1) % 8;
    end
  endtask

  // Apply the current inputs to the reference model and queue the expected result.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int   cur = m_q[k];
      int   nxt = cur;
      logic t   = 1'b0;
      int   m   = int'(mod_v[k]);
      if (!load_n) begin
        nxt = int'(d);
      end else if (en) begin
        case (mode)
          2'd0: begin nxt = (cur >= m - 1) ? 0 : cur + 1; t = (nxt == 0); end
          2'd1: begin
            if (cur == 0) begin nxt = m - 1; t = 1'b1; end
            else nxt = cur - 1;
          end
          2'd2: begin nxt = b2g((g2b(cur) + 1) % 8); t = (nxt == 0); end
          default: begin nxt = m_tbl[k][cur]; t = (nxt == 0); end
        endcase
      end
      if (tbl_we) m_tbl[k][tbl_addr] = int'(tbl_wdata);
      m_q[k]  = nxt;
      m_tc[k] = t;
    end
    exp0.push_back('{q: 3'(m_q[0]), tc: m_tc[0]});
    exp1.push_back('{q: 3'(m_q[1]), tc: m_tc[1]});
  endtask

  task automatic drive(input logic e, input logic ln, input logic [2:0] dv, input logic [1:0] md,
                       input logic we, input logic [2:0] wa, input logic [2:0] wd);
    @(negedge clk);
    en = e; load_n = ln; d = dv; mode = md;
    tbl_we = we; tbl_addr = wa; tbl_wdata = wd;
    model_step();
  endtask

  task automatic async_reset();
    exp_t z;
    z = '{q: 3'd0, tc: 1'b0};
    @(posedge clk);
    #3;
    en = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_m8", bus8.q, bus8.tc, z);
    check("async_rst_m6", bus6.q, bus6.tc, z);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0; load_n = 1'b1; tbl_we = 1'b0;
    model_step();
  endtask

  // Monitor: every clock the counters present a new q/tc; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp0.size() > 0) begin
        e = exp0.pop_front();
        check("step_m8", bus8.q, bus8.tc, e);
      end
      if (exp1.size() > 0) begin
        e = exp1.pop_front();
        check("step_m6", bus6.q, bus6.tc, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] wa [6];
    logic [2:0] wd [6];
    exp_t       z;
    wa = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7, 3'd2};
    wd = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd0};
    z  = '{q: 3'd0, tc: 1'b0};

    rst_n = 1'b0;
    en = 1'b0; load_n = 1'b1; d = '0; mode = 2'd0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_m8", bus8.q, bus8.tc, z);
    check("reset_m6", bus6.q, bus6.tc, z);
    @(negedge clk);
    rst_n = 1'b1;
    model_step();

    // Up count through the wrap, then reset in the middle of counting.
    repeat (10) drive(1, 1, 0, 2'd0, 0, 0, 0);
    async_reset();

    // Modulus boundaries: load 5 / 7 and step up, then down from 0.
    drive(0, 0, 5, 2'd0, 0, 0, 0);
    repeat (2) drive(1, 1, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 7, 2'd0, 0, 0, 0);
    repeat (2) drive(1, 1, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 0, 2'd1, 0, 0, 0);
    repeat (3) drive(1, 1, 0, 2'd1, 0, 0, 0);

    // Gray sequence from 0.
    drive(0, 0, 0, 2'd2, 0, 0, 0);
    repeat (9) drive(1, 1, 0, 2'd2, 0, 0, 0);

    // Programmed table cycle, then rewrite entry 3 to a self-loop while stepping from 3.
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 2'd3, 1, wa[i], wd[i]);
    drive(0, 0, 0, 2'd3, 0, 0, 0);
    repeat (12) drive(1, 1, 0, 2'd3, 0, 0, 0);
    drive(0, 0, 0, 2'd3, 0, 0, 0);
    repeat (2) drive(1, 1, 0, 2'd3, 0, 0, 0);
    drive(1, 1, 0, 2'd3, 1, 3'd3, 3'd3);
    repeat (7) drive(1, 1, 0, 2'd3, 0, 0, 0);

    // Load beats enable; hold clears tc.
    drive(1, 0, 4, 2'd0, 0, 0, 0);
    repeat (2) drive(0, 1, 0, 2'd0, 0, 0, 0);

    // Mode switches without re-encoding.
    drive(0, 0, 6, 2'd0, 0, 0, 0);
    repeat (2) drive(1, 1, 0, 2'd1, 0, 0, 0);
    drive(0, 0, 2, 2'd1, 0, 0, 0);
    drive(1, 1, 0, 2'd2, 0, 0, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (i % 150 == 149) async_reset();
      drive(($urandom_range(3) != 0), ($urandom_range(7) != 0), 3'($urandom_range(7)),
            2'($urandom_range(3)), ($urandom_range(3) == 0), 3'($urandom_range(7)),
            3'($urandom_range(7)));
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0/0", exp0.size(),
               exp1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
